// File: rtl/uart_kbd_fifo.sv
// uart_kbd_fifo: byte FIFO between the UART receiver and the LC-3 bus.
// Exposes KBSR (ready/ie/ovf/count) and KBDR (pop), drives the keyboard
// interrupt request and throttles the receiver when the buffer is full.
module uart_kbd_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Rx_Enable,
   input  logic        i_Sel_KBSR,
   input  logic        i_Sel_KBDR,
   input  logic        i_Rd,
   input  logic        i_Wr,
   input  logic [15:0] i_Wdata,
   output logic [15:0] o_Rdata,
   output logic        o_Int_Req
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ie_q, ie_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       rdata_q, rdata_d;

   logic empty, full;
   logic kbdr_hit, kbsr_hit;
   logic pop, push, ovf_evt;
   logic [15:0] status;
   logic unused_wdata;

   // Only bits 14 (ie) and 13 (ovf clear) of a KBSR write carry meaning.
   assign unused_wdata = ^{i_Wdata[15], i_Wdata[12:0]};

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   // KBDR wins when both decodes hit, suppressing any KBSR effect.
   assign kbdr_hit = i_Sel_KBDR;
   assign kbsr_hit = i_Sel_KBSR & ~i_Sel_KBDR;
   assign pop      = i_Rd & kbdr_hit & ~empty;
   // A same-cycle pop frees a slot, so a full FIFO can still accept a byte.
   assign push     = i_Rx_DV & (~full | pop);
   assign ovf_evt  = i_Rx_DV & full & ~pop;
   assign status   = {~empty, ie_q, ovf_q, 8'h00, 5'(count_q)};

   assign o_Rx_Enable = ~full;
   assign o_Int_Req   = ~empty & ie_q;
   assign o_Rdata     = rdata_q;

   // Next-state for pointers, count, control bits and the read data register.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ie_d     = ie_q;
      ovf_d    = ovf_q;
      rdata_d  = rdata_q;

      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase

      if (i_Wr & kbsr_hit) begin
         ie_d = i_Wdata[14];
         if (i_Wdata[13]) ovf_d = 1'b0;
      end
      // Overflow in the same cycle as a clear keeps the flag set.
      if (ovf_evt) ovf_d = 1'b1;

      if (i_Rd & kbdr_hit)
         rdata_d = pop ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
      else if (i_Rd & kbsr_hit)
         rdata_d = status;
   end

   // Control and read-data registers with synchronous reset.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ie_q     <= 1'b0;
         ovf_q    <= 1'b0;
         rdata_q  <= 16'h0000;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ie_q     <= ie_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
      end
   end

   // Byte storage; contents are not reset, a byte arriving during reset is dropped.
   always_ff @(posedge i_Clock) begin
      if (push && !i_Reset) mem_q[wr_ptr_q] <= i_Rx_Byte;
   end

endmodule

// File: tb/tb_uart_kbd_fifo.sv
// tb_uart_kbd_fifo: directed, table-driven bench for uart_kbd_fifo.
module tb_uart_kbd_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        rx_en;
   logic        sel_kbsr, sel_kbdr, rd, wr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        int_req;

   int n_cmp = 0;
   int n_err = 0;

   uart_kbd_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .i_Clock    (clk),
      .i_Reset    (rst),
      .i_Rx_DV    (rx_dv),
      .i_Rx_Byte  (rx_byte),
      .o_Rx_Enable(rx_en),
      .i_Sel_KBSR (sel_kbsr),
      .i_Sel_KBDR (sel_kbdr),
      .i_Rd       (rd),
      .i_Wr       (wr),
      .i_Wdata    (wdata),
      .o_Rdata    (rdata),
      .o_Int_Req  (int_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [7:0]  byte_in;
      logic        ss;
      logic        sd;
      logic        r;
      logic        w;
      logic [15:0] wd;
      logic [15:0] exp_rdata;
      logic        exp_rx_en;
      logic        exp_int;
   } vec_t;

   vec_t vt[19];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      rx_dv = 1'b0; rx_byte = 8'h00; sel_kbsr = 1'b0; sel_kbdr = 1'b0;
      rd = 1'b0; wr = 1'b0; wdata = 16'h0000;
   endtask

   // Apply inputs for one rising edge, then return inputs to idle 1ns after it.
   task automatic drive(input logic dv, input logic [7:0] b, input logic ss, input logic sd,
                        input logic r, input logic w, input logic [15:0] wd);
      rx_dv = dv; rx_byte = b; sel_kbsr = ss; sel_kbdr = sd; rd = r; wr = w; wdata = wd;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic push(input logic [7:0] b);
      drive(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic rd_kbsr(input string name, input logic [15:0] exp);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk(name, rdata, exp);
   endtask

   task automatic rd_kbdr(input string name, input logic [15:0] exp);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      chk(name, rdata, exp);
   endtask

   task automatic wr_kbsr(input logic [15:0] wd);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, wd);
   endtask

   initial begin
      //        dv    byte   ss    sd    rd    wr    wdata     rdata     rxen  int
      vt[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vt[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h8002, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0041, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0042, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0};
      vt[7]  = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
      vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h000D, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h000D, 1'b1, 1'b1};
      vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h007A, 1'b1, 1'b0};
      vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h4000, 1'b1, 1'b0};
      vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000, 1'b1, 1'b0};
      vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vt[14] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0};
      vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0011, 1'b1, 1'b0};
      vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0};
      vt[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h4000, 1'b1, 1'b0};
      vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000, 1'b1, 1'b0};

      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset rdata", rdata, 16'h0000);
      chk("reset rx_en", {15'h0, rx_en}, 16'h0001);
      chk("reset int",   {15'h0, int_req}, 16'h0000);

      // Basic push/read, interrupt enable, select priority, rd+wr together.
      for (int i = 0; i < 19; i++) begin
         drive(vt[i].dv, vt[i].byte_in, vt[i].ss, vt[i].sd, vt[i].r, vt[i].w, vt[i].wd);
         chk($sformatf("row%0d rdata", i), rdata, vt[i].exp_rdata);
         chk($sformatf("row%0d rx_en", i), {15'h0, rx_en}, {15'h0, vt[i].exp_rx_en});
         chk($sformatf("row%0d int", i), {15'h0, int_req}, {15'h0, vt[i].exp_int});
      end

      // Fill to full, overflow, W1C of ovf and overflow-wins-over-clear.
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk($sformatf("fill%0d rx_en", i), {15'h0, rx_en}, (i < 15) ? 16'h0001 : 16'h0000);
      end
      push(8'h99);
      chk("ovf push rx_en", {15'h0, rx_en}, 16'h0000);
      rd_kbsr("kbsr full ovf", 16'hA010);
      wr_kbsr(16'h2000);
      rd_kbsr("kbsr ovf cleared", 16'h8010);
      drive(1'b1, 8'h98, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2000);
      rd_kbsr("kbsr ovf wins", 16'hA010);
      wr_kbsr(16'h2000);
      rd_kbsr("kbsr ovf cleared2", 16'h8010);
      for (int i = 0; i < 16; i++)
         rd_kbdr($sformatf("drain%0d", i), {8'h00, 8'(i)});
      rd_kbsr("kbsr drained", 16'h0000);

      // Full FIFO with simultaneous push and pop.
      for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
      drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      chk("pushpop rdata", rdata, 16'h0020);
      chk("pushpop rx_en", {15'h0, rx_en}, 16'h0000);
      rd_kbsr("kbsr pushpop", 16'h8010);
      for (int i = 1; i < 16; i++)
         rd_kbdr($sformatf("wrap%0d", i), {8'h00, 8'h20 + 8'(i)});
      rd_kbdr("wrap last", 16'h0055);
      rd_kbsr("kbsr after wrap", 16'h0000);

      // Empty KBDR read, then reset concurrent with a byte strobe.
      wr_kbsr(16'h4000);
      rd_kbdr("kbdr empty", 16'h0000);
      rd_kbsr("kbsr empty ie", 16'h4000);
      rst = 1'b1;
      push(8'h31);
      rst = 1'b0;
      chk("rst push rdata", rdata, 16'h0000);
      chk("rst push rx_en", {15'h0, rx_en}, 16'h0001);
      chk("rst push int",   {15'h0, int_req}, 16'h0000);
      rd_kbsr("kbsr after rst", 16'h0000);
      rd_kbdr("kbdr after rst", 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
